cpu_mem_arbiter: RTL and testbench

- Shares one single-port BRAM between two CPU requesters: instruction fetch and data load/store.
- Arbitrates between them (round-robin on contention) and sequences each access through a fixed-latency BRAM read.
- For data accesses, generates byte-lane write enables and write-data alignment; for loads, sign- or zero-extends the read data.
- Sits between cpu core ports and the BRAM; one transaction outstanding at a time.

---
 rtl/cpu_mem_pkg.sv | 28 ++
 rtl/cpu_lsu_align.sv | 49 ++++
 rtl/cpu_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and lane constants for the CPU-to-BRAM arbiter slice.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'd0,
        HALF    = 2'd1,
        WORD    = 2'd2,
        ILLEGAL = 2'd3
    } mem_size_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_WAIT   = 3'd2,
        S_RESP   = 3'd3,
        S_ERR    = 3'd4
    } arb_state_e;

    typedef enum logic {
        REQ_INST = 1'b0,
        REQ_DATA = 1'b1
    } req_id_e;

    localparam logic [3:0] LANE_B = 4'b0001;
    localparam logic [3:0] LANE_H = 4'b0011;
    localparam logic [3:0] LANE_W = 4'b1111;

endpackage

// File: rtl/cpu_lsu_align.sv
// Combinational data-path helper: misalign detection, store lane steering,
// load byte/half extraction with sign or zero extension.
module cpu_lsu_align
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  mem_size_e   size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        misalign,
    output logic [3:0]  we_mask,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata_ext
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata[8*addr_lo +: 8];
    assign half_v = rdata[16*addr_lo[1] +: 16];

    always_comb begin
        misalign  = 1'b0;
        we_mask   = 4'b0000;
        wdata_al  = wdata;
        rdata_ext = '0;
        case (size)
            BYTE: begin
                we_mask   = LANE_B << addr_lo;
                wdata_al  = {4{wdata[7:0]}};
                rdata_ext = {{24{~is_unsigned & byte_v[7]}}, byte_v};
            end
            HALF: begin
                misalign  = addr_lo[0];
                we_mask   = LANE_H << addr_lo;
                wdata_al  = {2{wdata[15:0]}};
                rdata_ext = {{16{~is_unsigned & half_v[15]}}, half_v};
            end
            WORD: begin
                misalign  = |addr_lo;
                we_mask   = LANE_W;
                rdata_ext = rdata;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between fetch and load/store,
// one transaction in flight, fixed read latency.
module cpu_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [1:0]        data_size,
    input  logic              data_unsigned,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [31:0]       data_rdata,
    output logic              data_err,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we
);

    arb_state_e state;
    req_id_e    last_grant, cur, pick;
    logic [2:0] cnt;
    logic [1:0] cap_lo;
    mem_size_e  cap_size;
    logic       cap_uns, cap_we;

    logic [1:0]  al_lo;
    mem_size_e   al_size;
    logic        al_uns, misalign;
    logic [3:0]  we_mask;
    logic [31:0] wdata_al, rdata_ext;

    // Contention goes to whoever did not win last; a lone requester always wins.
    assign pick = (data_req && (!inst_req || last_grant == REQ_INST)) ? REQ_DATA : REQ_INST;

    // In IDLE the helper steers the live store request; afterwards it formats the captured load.
    assign al_lo   = (state == S_IDLE) ? data_addr[1:0]            : cap_lo;
    assign al_size = (state == S_IDLE) ? mem_size_e'(data_size)    : cap_size;
    assign al_uns  = (state == S_IDLE) ? data_unsigned             : cap_uns;

    cpu_lsu_align u_align (
        .addr_lo     (al_lo),
        .size        (al_size),
        .is_unsigned (al_uns),
        .wdata       (data_wdata),
        .rdata       (mem_rdata),
        .misalign    (misalign),
        .we_mask     (we_mask),
        .wdata_al    (wdata_al),
        .rdata_ext   (rdata_ext)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= S_IDLE;
            last_grant  <= REQ_DATA;
            cur         <= REQ_INST;
            cnt         <= '0;
            cap_lo      <= '0;
            cap_size    <= BYTE;
            cap_uns     <= 1'b0;
            cap_we      <= 1'b0;
            inst_gnt    <= 1'b0;
            inst_rvalid <= 1'b0;
            inst_rdata  <= '0;
            data_gnt    <= 1'b0;
            data_rvalid <= 1'b0;
            data_rdata  <= '0;
            data_err    <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_en      <= 1'b0;
            mem_we      <= '0;
        end else begin
            inst_gnt    <= 1'b0;
            data_gnt    <= 1'b0;
            inst_rvalid <= 1'b0;
            data_rvalid <= 1'b0;
            data_err    <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= '0;
            case (state)
                S_IDLE: if (inst_req || data_req) begin
                    last_grant <= pick;
                    cur        <= pick;
                    cap_lo     <= data_addr[1:0];
                    cap_size   <= mem_size_e'(data_size);
                    cap_uns    <= data_unsigned;
                    cap_we     <= data_we;
                    if (pick == REQ_INST) begin
                        inst_gnt <= 1'b1;
                        mem_en   <= 1'b1;
                        mem_addr <= 32'(inst_addr >> 2);
                        state    <= S_ACCESS;
                    end else if (misalign) begin
                        data_gnt <= 1'b1;
                        state    <= S_ERR;
                    end else begin
                        data_gnt  <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_addr  <= 32'(data_addr >> 2);
                        mem_we    <= data_we ? we_mask : 4'b0000;
                        mem_wdata <= wdata_al;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    cnt   <= 3'(RD_LATENCY - 1);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        if (cur == REQ_INST) begin
                            inst_rvalid <= 1'b1;
                            inst_rdata  <= mem_rdata;
                        end else begin
                            data_rvalid <= 1'b1;
                            data_rdata  <= cap_we ? '0 : rdata_ext;
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_ERR: begin
                    data_rvalid <= 1'b1;
                    data_err    <= 1'b1;
                    data_rdata  <= '0;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    inst_rdata <= '0;
                    data_rdata <= '0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench: two arbiter instances (read latency 1 and 3) share stimulus and a BRAM model.
module tb_cpu_mem_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        inst_req, data_req, data_we, data_unsigned;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic [1:0]  data_size;

    logic        ig [2], irv [2], dg [2], drv [2], derr [2], men [2];
    logic [31:0] ird [2], drd [2], maddr [2], mwd [2], mrd [2];
    logic [3:0]  mwe [2];

    logic [31:0] mem [256];
    logic [31:0] p0;
    logic [31:0] p1 [3];
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init;
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  mwe;
        logic [31:0] mwd;
        logic [31:0] after;
    } vec_t;

    vec_t vecs [14];

    always #5 aclk = ~aclk;

    cpu_mem_arbiter #(.RD_LATENCY(1), .ADDR_W(32)) u_dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(ig[0]), .inst_rvalid(irv[0]), .inst_rdata(ird[0]),
        .data_req(data_req), .data_we(data_we), .data_size(data_size), .data_unsigned(data_unsigned),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(dg[0]), .data_rvalid(drv[0]),
        .data_rdata(drd[0]), .data_err(derr[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]),
        .mem_rdata(mrd[0]), .mem_en(men[0]), .mem_we(mwe[0])
    );

    cpu_mem_arbiter #(.RD_LATENCY(3), .ADDR_W(32)) u_dut3 (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(ig[1]), .inst_rvalid(irv[1]), .inst_rdata(ird[1]),
        .data_req(data_req), .data_we(data_we), .data_size(data_size), .data_unsigned(data_unsigned),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_gnt(dg[1]), .data_rvalid(drv[1]),
        .data_rdata(drd[1]), .data_err(derr[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]),
        .mem_rdata(mrd[1]), .mem_en(men[1]), .mem_we(mwe[1])
    );

    assign mrd[0] = p0;
    assign mrd[1] = p1[2];

    // BRAM model: read-before-write, byte-lane writes, per-instance read pipeline.
    always @(posedge aclk) begin
        if (pre_en) mem[pre_idx] <= pre_data;
        for (int i = 0; i < 2; i++)
            if (men[i])
                for (int b = 0; b < 4; b++)
                    if (mwe[i][b]) mem[maddr[i][7:0]][8*b +: 8] <= mwd[i][8*b +: 8];
        if (men[0]) p0 <= mem[maddr[0][7:0]];
        if (men[1]) p1[0] <= mem[maddr[1][7:0]];
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", name, i, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        @(negedge aclk);
        pre_en = 1'b1; pre_idx = idx; pre_data = d;
        @(negedge aclk);
        pre_en = 1'b0;
    endtask

    task automatic chk_zero(input string name);
        for (int i = 0; i < 2; i++)
            chk(name, i, 32'(|{ig[i], irv[i], ird[i], dg[i], drv[i], drd[i], derr[i],
                              maddr[i], mwd[i], men[i], mwe[i]}), 32'd0);
    endtask

    task automatic run_fetch(input logic [31:0] addr, input logic [31:0] word);
        int first [2];
        int pulses [2];
        preload(addr[9:2], word);
        inst_req = 1'b1; inst_addr = addr;
        @(negedge aclk);
        inst_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("fetch_gnt", i, 32'(ig[i]), 32'd1);
            chk("fetch_en", i, 32'(men[i]), 32'd1);
            chk("fetch_maddr", i, maddr[i], {2'b00, addr[31:2]});
            chk("fetch_we", i, 32'(mwe[i]), 32'd0);
            first[i] = -1; pulses[i] = 0;
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge aclk);
            for (int i = 0; i < 2; i++)
                if (irv[i]) begin
                    pulses[i]++;
                    if (first[i] < 0) first[i] = k;
                    chk("fetch_rdata", i, ird[i], word);
                end
        end
        for (int i = 0; i < 2; i++) begin
            chk("fetch_rvalid_cycle", i, 32'(first[i]), 32'(lat_of(i) + 1));
            chk("fetch_rvalid_pulses", i, 32'(pulses[i]), 32'd1);
        end
    endtask

    task automatic run_data(input vec_t v);
        int first [2];
        int pulses [2];
        logic en_seen [2];
        preload(v.addr[9:2], v.init);
        data_req = 1'b1; data_we = v.we; data_size = v.size; data_unsigned = v.uns;
        data_addr = v.addr; data_wdata = v.wdata;
        @(negedge aclk);
        data_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("data_gnt", i, 32'(dg[i]), 32'd1);
            chk("data_en", i, 32'(men[i]), 32'(!v.err));
            if (!v.err) begin
                chk("data_maddr", i, maddr[i], {2'b00, v.addr[31:2]});
                chk("data_we", i, 32'(mwe[i]), 32'(v.mwe));
                if (v.we) chk("data_wdata", i, mwd[i], v.mwd);
            end
            first[i] = -1; pulses[i] = 0; en_seen[i] = 1'b0;
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge aclk);
            for (int i = 0; i < 2; i++) begin
                if (men[i]) en_seen[i] = 1'b1;
                if (drv[i]) begin
                    pulses[i]++;
                    if (first[i] < 0) first[i] = k;
                    chk("data_rdata", i, drd[i], v.rdata);
                    chk("data_err", i, 32'(derr[i]), 32'(v.err));
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk("data_rvalid_cycle", i, 32'(first[i]), v.err ? 32'd1 : 32'(lat_of(i) + 1));
            chk("data_rvalid_pulses", i, 32'(pulses[i]), 32'd1);
            chk("data_en_after_gnt", i, 32'(en_seen[i]), 32'd0);
        end
        chk("mem_word_after", 0, mem[v.addr[9:2]], v.after);
    endtask

    initial begin
        int ng [2];
        logic seq [2][3];
        int rv_seen;
        bit done;

        //           we    size  uns   addr          wdata         init          err   rdata         mwe      mwd           after
        vecs[0]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00A5, 32'h1122_3344, 1'b0, 32'h0000_0000, 4'b1000, 32'hA5A5_A5A5, 32'hA522_3344};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0021, 32'h0,         32'h80FF_7F01, 1'b0, 32'h0000_007F, 4'b0000, 32'h0,         32'h80FF_7F01};
        vecs[2]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0022, 32'h0,         32'h80FF_7F01, 1'b0, 32'hFFFF_80FF, 4'b0000, 32'h0,         32'h80FF_7F01};
        vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0022, 32'h0,         32'h80FF_7F01, 1'b0, 32'h0000_80FF, 4'b0000, 32'h0,         32'h80FF_7F01};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0,         32'h80FF_7F01, 1'b0, 32'h80FF_7F01, 4'b0000, 32'h0,         32'h80FF_7F01};
        vecs[5]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0023, 32'h0,         32'h80FF_7F01, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0,         32'h80FF_7F01};
        vecs[6]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0023, 32'h0,         32'h80FF_7F01, 1'b0, 32'h0000_0080, 4'b0000, 32'h0,         32'h80FF_7F01};
        vecs[7]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0020, 32'h0,         32'h80FF_7F01, 1'b0, 32'h0000_0001, 4'b0000, 32'h0,         32'h80FF_7F01};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0,         32'h1234_5678, 1'b1, 32'h0000_0000, 4'b0000, 32'h0,         32'h1234_5678};
        vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0021, 32'h0,         32'h80FF_7F01, 1'b1, 32'h0000_0000, 4'b0000, 32'h0,         32'h80FF_7F01};
        vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,         32'h0BAD_F00D, 1'b1, 32'h0000_0000, 4'b0000, 32'h0,         32'h0BAD_F00D};
        vecs[11] = '{1'b1, 2'd1, 1'b0, 32'h0000_0032, 32'h1234_BEEF, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b1100, 32'hBEEF_BEEF, 32'hBEEF_0000};
        vecs[12] = '{1'b1, 2'd2, 1'b0, 32'h0000_0034, 32'hCAFE_F00D, 32'h5555_5555, 1'b0, 32'h0000_0000, 4'b1111, 32'hCAFE_F00D, 32'hCAFE_F00D};
        vecs[13] = '{1'b1, 2'd2, 1'b0, 32'h0000_0035, 32'hCAFE_F00D, 32'h7777_7777, 1'b1, 32'h0000_0000, 4'b0000, 32'h0,         32'h7777_7777};

        aresetn = 1'b0; inst_req = 1'b0; data_req = 1'b0; data_we = 1'b0; data_size = 2'd2;
        data_unsigned = 1'b0; inst_addr = 32'h10; data_addr = 32'h20; data_wdata = '0;
        pre_en = 1'b0; pre_idx = '0; pre_data = '0;
        repeat (3) @(negedge aclk);
        chk_zero("reset_outputs");

        // Contention from reset: both held, expect inst, data, inst on each instance.
        inst_req = 1'b1; data_req = 1'b1;
        @(negedge aclk);
        aresetn = 1'b1;
        ng[0] = 0; ng[1] = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge aclk);
            for (int i = 0; i < 2; i++) begin
                if (ig[i] && ng[i] < 3) begin seq[i][ng[i]] = 1'b0; ng[i]++; end
                else if (dg[i] && ng[i] < 3) begin seq[i][ng[i]] = 1'b1; ng[i]++; end
            end
            done = (ng[0] == 3) && (ng[1] == 3);
        end
        inst_req = 1'b0; data_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rr_grant_count", i, 32'(ng[i]), 32'd3);
            if (ng[i] == 3) begin
                chk("rr_first_inst", i, 32'(seq[i][0]), 32'd0);
                chk("rr_second_data", i, 32'(seq[i][1]), 32'd1);
                chk("rr_third_inst", i, 32'(seq[i][2]), 32'd0);
            end
        end
        repeat (12) @(negedge aclk);

        run_fetch(32'h0000_0010, 32'hDEAD_BEEF);
        for (int v = 0; v < 14; v++) run_data(vecs[v]);

        // Reset while the fetch sits in WAIT: no response may follow.
        preload(8'h05, 32'h0F0F_0F0F);
        inst_req = 1'b1; inst_addr = 32'h14;
        @(negedge aclk);
        inst_req = 1'b0;
        for (int i = 0; i < 2; i++) chk("abort_gnt", i, 32'(ig[i]), 32'd1);
        @(negedge aclk);
        aresetn = 1'b0;
        @(negedge aclk);
        chk_zero("abort_outputs_zero");
        aresetn = 1'b1;
        rv_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            for (int i = 0; i < 2; i++) if (irv[i] || drv[i]) rv_seen++;
        end
        chk("abort_no_rvalid", 0, 32'(rv_seen), 32'd0);

        run_fetch(32'h0000_0018, 32'h1234_5678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
